// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: during hblank it pulls each active sprite's current row from the
// sprite ROM into shadow buffers, commits them, and resolves per-pixel hits while drawing.
module sprite_line_fetcher #(
  parameter int NUM_SPR  = 4,
  parameter int SPR_SIZE = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  line_start,
  input  logic [9:0]            line_y,
  input  logic [10*NUM_SPR-1:0] spr_x,
  input  logic [10*NUM_SPR-1:0] spr_y,
  input  logic [2*NUM_SPR-1:0]  spr_type,
  input  logic [NUM_SPR-1:0]    spr_active,
  output logic [10:0]           rom_addr,
  input  logic [15:0]           rom_data,
  input  logic [9:0]            draw_x,
  output logic                  pixel_on,
  output logic [1:0]            pixel_type,
  output logic [2:0]            pixel_idx,
  output logic                  busy,
  output logic                  line_ready
);

  localparam logic [10:0] LAST_OFS  = 11'(SPR_SIZE - 1);
  localparam logic [10:0] ROM_TOP   = 11'(3 * SPR_SIZE - 1);
  localparam logic [3:0]  LEFT_BIT  = 4'(SPR_SIZE - 1);
  localparam logic [2:0]  LAST_SLOT = 3'(NUM_SPR - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMMIT
  } state_t;

  state_t      state, state_next;
  logic [2:0]  k, k_next;
  logic [9:0]  line_q;

  logic [15:0] shadow_row  [NUM_SPR];
  logic [9:0]  shadow_x    [NUM_SPR];
  logic [1:0]  shadow_type [NUM_SPR];
  logic [15:0] disp_row    [NUM_SPR];
  logic [9:0]  disp_x      [NUM_SPR];
  logic [1:0]  disp_type   [NUM_SPR];

  logic [9:0]  cur_x, cur_y;
  logic [1:0]  cur_type;
  logic        cur_active;
  logic [10:0] row;
  logic        visible;
  logic        commit;

  logic [10:0] d;
  logic        hit;
  logic [1:0]  hit_type;
  logic [2:0]  hit_idx;

  always_comb begin
    cur_x      = '0;
    cur_y      = '0;
    cur_type   = '0;
    cur_active = 1'b0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (k == 3'(i)) begin
        cur_x      = spr_x[10*i +: 10];
        cur_y      = spr_y[10*i +: 10];
        cur_type   = spr_type[2*i +: 2];
        cur_active = spr_active[i];
      end
    end
  end

  // Underflow when the sprite starts below line_q is rejected by the explicit >= test.
  always_comb begin
    row      = {1'b0, line_q} - {1'b0, cur_y};
    visible  = (state == FETCH) && cur_active && (cur_type != 2'd3) &&
               (line_q >= cur_y) && (row <= LAST_OFS);
    rom_addr = visible ? (ROM_TOP - {5'd0, cur_type, row[3:0]}) : 11'd0;
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    unique case (state)
      IDLE: begin
        if (line_start) begin
          state_next = FETCH;
          k_next     = '0;
        end
      end
      FETCH: begin
        if (line_start) begin
          k_next = '0;
        end else if (k == LAST_SLOT) begin
          state_next = COMMIT;
        end else begin
          k_next = k + 3'd1;
        end
      end
      COMMIT: begin
        if (line_start) begin
          state_next = FETCH;
          k_next     = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A restart arriving in the COMMIT cycle discards the fetched line.
  assign commit     = (state == COMMIT) && !line_start;
  assign busy       = (state != IDLE);
  assign line_ready = commit;

  // Iterating downward lets the lowest-indexed hitting slot win.
  always_comb begin
    d        = '0;
    hit      = 1'b0;
    hit_type = '0;
    hit_idx  = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      d = {1'b0, draw_x} - {1'b0, disp_x[i]};
      if ((draw_x >= disp_x[i]) && (d <= LAST_OFS) && disp_row[i][LEFT_BIT - d[3:0]]) begin
        hit      = 1'b1;
        hit_type = disp_type[i];
        hit_idx  = 3'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      k          <= '0;
      line_q     <= '0;
      pixel_on   <= 1'b0;
      pixel_type <= '0;
      pixel_idx  <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_row[i]  <= '0;
        shadow_x[i]    <= '0;
        shadow_type[i] <= '0;
        disp_row[i]    <= '0;
        disp_x[i]      <= '0;
        disp_type[i]   <= '0;
      end
    end else begin
      state <= state_next;
      k     <= k_next;
      if (line_start) begin
        line_q <= line_y;
      end
      for (int i = 0; i < NUM_SPR; i++) begin
        if ((state == FETCH) && (k == 3'(i))) begin
          if (visible) begin
            shadow_row[i]  <= rom_data;
            shadow_x[i]    <= cur_x;
            shadow_type[i] <= cur_type;
          end else begin
            shadow_row[i] <= '0;
          end
        end
        if (commit) begin
          disp_row[i]  <= shadow_row[i];
          disp_x[i]    <= shadow_x[i];
          disp_type[i] <= shadow_type[i];
        end
      end
      pixel_on   <= hit;
      pixel_type <= hit_type;
      pixel_idx  <= hit_idx;
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher: fetch sequences with hand-computed ROM addresses
// and a table of draw_x probes with expected hit/type/index.
module tb_sprite_line_fetcher;

  localparam int NUM_SPR = 4;

  logic                  Clk;
  logic                  Reset_n;
  logic                  line_start;
  logic [9:0]            line_y;
  logic [10*NUM_SPR-1:0] spr_x;
  logic [10*NUM_SPR-1:0] spr_y;
  logic [2*NUM_SPR-1:0]  spr_type;
  logic [NUM_SPR-1:0]    spr_active;
  logic [10:0]           rom_addr;
  logic [15:0]           rom_data;
  logic [9:0]            draw_x;
  logic                  pixel_on;
  logic [1:0]            pixel_type;
  logic [2:0]            pixel_idx;
  logic                  busy;
  logic                  line_ready;

  int total;
  int bad;

  typedef struct {
    int         scen;
    logic [9:0] x;
    logic       on;
    logic [1:0] typ;
    logic [2:0] idx;
  } draw_vec_t;

  localparam int NV = 19;
  draw_vec_t vecs [NV];

  sprite_line_fetcher #(.NUM_SPR(NUM_SPR), .SPR_SIZE(16)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .line_start (line_start),
    .line_y     (line_y),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_type   (spr_type),
    .spr_active (spr_active),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .draw_x     (draw_x),
    .pixel_on   (pixel_on),
    .pixel_type (pixel_type),
    .pixel_idx  (pixel_idx),
    .busy       (busy),
    .line_ready (line_ready)
  );

  // Sprite ROM model: only the rows the scenarios touch hold meaningful patterns.
  function automatic logic [15:0] romModel(input logic [10:0] a);
    case (a)
      11'd0:   romModel = 16'h8102;
      11'd25:  romModel = 16'h0180;
      11'd43:  romModel = 16'h2001;
      default: romModel = 16'h5A5A;
    endcase
  endfunction

  assign rom_data = romModel(rom_addr);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x);
    draw_x = x;
    @(negedge Clk);
  endtask

  task automatic setSlot(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic [1:0] t, input logic a);
    spr_x[i*10 +: 10] = x;
    spr_y[i*10 +: 10] = y;
    spr_type[i*2 +: 2] = t;
    spr_active[i]      = a;
  endtask

  task automatic fetchLine(input logic [9:0] ly, input logic [10:0] a0, input logic [10:0] a1,
                           input logic [10:0] a2, input logic [10:0] a3);
    logic [10:0] exp_addr [4];
    exp_addr[0] = a0;
    exp_addr[1] = a1;
    exp_addr[2] = a2;
    exp_addr[3] = a3;
    line_y     = ly;
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("fetch_busy", busy, 1);
      checkOutput("fetch_ready_early", line_ready, 0);
      checkOutput("fetch_rom_addr", rom_addr, exp_addr[c]);
      @(negedge Clk);
    end
    checkOutput("commit_busy", busy, 1);
    checkOutput("commit_ready", line_ready, 1);
    checkOutput("commit_rom_addr", rom_addr, 0);
    @(negedge Clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_ready", line_ready, 0);
  endtask

  task automatic runDraws(input int scen);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].scen == scen) begin
        applyStimulus(vecs[i].x);
        checkOutput("draw_on", pixel_on, vecs[i].on);
        checkOutput("draw_type", pixel_type, vecs[i].typ);
        checkOutput("draw_idx", pixel_idx, vecs[i].idx);
      end
    end
  endtask

  task automatic checkSpanOff(input logic [9:0] x0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(x0 + 10'(i));
      checkOutput("span_on", pixel_on, 0);
      checkOutput("span_idx", pixel_idx, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 10'd202,  1'b1, 2'd0, 3'd0};
    vecs[1]  = '{1, 10'd201,  1'b0, 2'd0, 3'd0};
    vecs[2]  = '{1, 10'd216,  1'b0, 2'd0, 3'd0};
    vecs[3]  = '{1, 10'd200,  1'b0, 2'd0, 3'd0};
    vecs[4]  = '{1, 10'd215,  1'b1, 2'd0, 3'd0};
    vecs[5]  = '{1, 10'd1017, 1'b1, 2'd0, 3'd3};
    vecs[6]  = '{1, 10'd1023, 1'b0, 2'd0, 3'd0};
    vecs[7]  = '{2, 10'd50,   1'b1, 2'd2, 3'd1};
    vecs[8]  = '{2, 10'd57,   1'b1, 2'd2, 3'd1};
    vecs[9]  = '{2, 10'd64,   1'b1, 2'd2, 3'd1};
    vecs[10] = '{2, 10'd51,   1'b0, 2'd0, 3'd0};
    vecs[11] = '{2, 10'd202,  1'b0, 2'd0, 3'd0};
    vecs[12] = '{3, 10'd407,  1'b1, 2'd1, 3'd0};
    vecs[13] = '{3, 10'd408,  1'b1, 2'd1, 3'd0};
    vecs[14] = '{3, 10'd406,  1'b0, 2'd0, 3'd0};
    vecs[15] = '{4, 10'd407,  1'b1, 2'd1, 3'd2};
    vecs[16] = '{4, 10'd408,  1'b1, 2'd1, 3'd2};
    vecs[17] = '{4, 10'd406,  1'b0, 2'd0, 3'd0};
    vecs[18] = '{5, 10'd407,  1'b0, 2'd0, 3'd0};

    total      = 0;
    bad        = 0;
    Reset_n    = 1'b0;
    line_start = 1'b0;
    line_y     = '0;
    spr_x      = '0;
    spr_y      = '0;
    spr_type   = '0;
    spr_active = '0;
    draw_x     = '0;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", line_ready, 0);
    checkOutput("reset_rom_addr", rom_addr, 0);
    checkOutput("reset_pixel_on", pixel_on, 0);
    checkOutput("reset_pixel_type", pixel_type, 0);
    checkOutput("reset_pixel_idx", pixel_idx, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    $display("[TB] enemy at (200,100) plus clipped enemy at x=1015");
    setSlot(0, 10'd200, 10'd100, 2'd0, 1'b1);
    setSlot(3, 10'd1015, 10'd100, 2'd0, 1'b1);
    fetchLine(10'd104, 11'd43, 11'd0, 11'd0, 11'd43);
    runDraws(1);

    $display("[TB] user ship at (50,300)");
    setSlot(1, 10'd50, 10'd300, 2'd2, 1'b1);
    setSlot(3, 10'd0, 10'd0, 2'd0, 1'b0);
    fetchLine(10'd315, 11'd0, 11'd0, 11'd0, 11'd0);
    runDraws(2);

    $display("[TB] overlapping shots");
    setSlot(0, 10'd400, 10'd10, 2'd1, 1'b1);
    setSlot(1, 10'd0, 10'd0, 2'd0, 1'b0);
    setSlot(2, 10'd400, 10'd10, 2'd1, 1'b1);
    fetchLine(10'd16, 11'd25, 11'd0, 11'd25, 11'd0);
    runDraws(3);
    setSlot(0, 10'd400, 10'd10, 2'd1, 1'b0);
    fetchLine(10'd16, 11'd0, 11'd0, 11'd25, 11'd0);
    runDraws(4);

    $display("[TB] vertical boundaries and invalid type");
    setSlot(0, 10'd300, 10'd100, 2'd0, 1'b1);
    setSlot(2, 10'd0, 10'd0, 2'd0, 1'b0);
    fetchLine(10'd99, 11'd0, 11'd0, 11'd0, 11'd0);
    runDraws(5);
    checkSpanOff(10'd300);
    fetchLine(10'd116, 11'd0, 11'd0, 11'd0, 11'd0);
    checkSpanOff(10'd300);
    setSlot(0, 10'd300, 10'd100, 2'd3, 1'b1);
    fetchLine(10'd104, 11'd0, 11'd0, 11'd0, 11'd0);
    checkSpanOff(10'd300);

    $display("[TB] abort and restart");
    setSlot(0, 10'd200, 10'd100, 2'd0, 1'b1);
    fetchLine(10'd104, 11'd43, 11'd0, 11'd0, 11'd0);
    applyStimulus(10'd202);
    checkOutput("abort_pre_on", pixel_on, 1);
    line_y     = 10'd500;
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checkOutput("abort_first_busy", busy, 1);
      checkOutput("abort_first_ready", line_ready, 0);
      checkOutput("abort_first_on", pixel_on, 1);
      if (c == 1) begin
        line_y     = 10'd104;
        line_start = 1'b1;
      end
      @(negedge Clk);
      line_start = 1'b0;
    end
    for (int c = 1; c <= 4; c++) begin
      checkOutput("abort_busy", busy, 1);
      checkOutput("abort_ready", line_ready, 0);
      checkOutput("abort_on", pixel_on, 1);
      checkOutput("abort_rom_addr", rom_addr, (c == 1) ? 16'd43 : 16'd0);
      @(negedge Clk);
    end
    checkOutput("abort_commit_ready", line_ready, 1);
    checkOutput("abort_commit_on", pixel_on, 1);
    @(negedge Clk);
    checkOutput("abort_done_busy", busy, 0);
    checkOutput("abort_done_on", pixel_on, 1);

    $display("[TB] reset during fetch");
    line_y     = 10'd104;
    line_start = 1'b1;
    @(negedge Clk);
    line_start = 1'b0;
    checkOutput("rstmid_busy_before", busy, 1);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_on", pixel_on, 0);
    checkOutput("rstmid_ready", line_ready, 0);
    checkOutput("rstmid_rom_addr", rom_addr, 0);
    Reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      checkOutput("rstmid_no_ready", line_ready, 0);
      checkOutput("rstmid_cleared_on", pixel_on, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Reader side of the sprite ROM interface: drives the 11-bit ROM address, consumes the 16-bit row word and turns the sprite table into per-pixel hits for the VGA colour mapper.
- During horizontal blank it fetches the current scanline's row of every active sprite into shadow buffers, then commits them to display buffers.
- While drawing, it answers "is draw_x covered by a sprite, and which one" with one cycle of latency.

Parameters:
- NUM_SPR, 4, number of sprite slots (1..8).
- SPR_SIZE, 16, sprite width/height in pixels. Fixed by the ROM row width.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- line_start  in  1  one-cycle pulse requesting a fetch for line_y
- line_y  in  10  scanline to be drawn next
- spr_x  in  10*NUM_SPR  left x of each slot; slot i occupies bits [10i+9:10i]
- spr_y  in  10*NUM_SPR  top y of each slot
- spr_type  in  2*NUM_SPR  0=enemy, 1=shot, 2=user ship, 3=invalid
- spr_active  in  NUM_SPR  slot enable
- rom_addr  out  11  sprite ROM address
- rom_data  in  16  sprite ROM row, combinational from rom_addr; bit 15 = leftmost pixel
- draw_x  in  10  current pixel column
- pixel_on  out  1  registered hit
- pixel_type  out  2  type of the winning slot
- pixel_idx  out  3  index of the winning slot
- busy  out  1  fetch in progress
- line_ready  out  1  one-cycle pulse when display buffers are committed

Behaviour:
- ROM map (decided): address = 47 − (16·type + row), where row 0 is the sprite top. rom_addr is 0 whenever no fetch is issuing.
- Reset (Reset_n=0 at a Clk edge): FSM=IDLE; all shadow and display rows cleared to 0; pixel_on=0, pixel_type=0, pixel_idx=0, busy=0, line_ready=0, rom_addr=0. Reset mid-fetch aborts the fetch with no commit.
- FSM IDLE: on line_start, latch line_y, set slot counter k=0, go to FETCH.
- FSM FETCH: one slot per cycle. row = line_y − spr_y[k], computed as an 11-bit unsigned difference.
  - Slot is visible if spr_active[k], type≠3, line_y ≥ spr_y[k] and row ≤ 15.
  - Visible: rom_addr is driven this cycle, rom_data is captured into shadow_row[k], and spr_x[k] and type are captured into shadow_x[k] and shadow_type[k].
  - Not visible: shadow_row[k]=0.
  - After k=NUM_SPR−1, go to COMMIT.
  - busy=1 in FETCH and COMMIT.
- FSM COMMIT: copy all shadow buffers to display buffers in one cycle, pulse line_ready, return to IDLE.
  - Fetch-to-ready latency is NUM_SPR+1 cycles after line_start.
- line_start while busy: restart from k=0 with the new line_y. Nothing is committed from the aborted fetch, and the display buffers keep their old contents.
- Sprite table inputs are sampled only during the slot's FETCH cycle. Later changes do not affect the current line.
- Draw path (runs in every state, always from the display buffers):
  - Offset d = draw_x − disp_x[i], 11-bit.
  - Slot i hits if draw_x ≥ disp_x[i], d ≤ 15 and disp_row[i][15−d]=1.
  - Lowest index wins. pixel_type and pixel_idx come from the winner and are registered, so they appear the cycle after draw_x.
  - With no hit: pixel_on=0 and pixel_type/pixel_idx hold 0.
- Edge boundaries: a sprite with x > 1008 is simply clipped at draw_x=1023; draw_x does not wrap. A sprite with y > line_y, where the subtraction underflows, is not visible.

Test Plan:
- Reset, then line_start with line_y=104 and slot0 enemy at (200,100) active, other slots inactive.
  - Expected: busy for 5 cycles, rom_addr=43 in cycle 1, line_ready pulse at cycle 5.
  - Then draw_x=202 → pixel_on=1 and pixel_idx=0 one cycle later; draw_x=201 → pixel_on=0; draw_x=216 → 0.
- Slot1 user ship at (50,300), line_y=315.
  - Expected: rom_addr=0, row 1000000100000010.
  - draw_x=50, 57 and 64 → pixel_on=1 with type 2; draw_x=51 → 0.
- Overlap: slot0 and slot2 both shots at (400,10), line_y=16.
  - Expected: rom_addr=25 for both; draw_x=407 → pixel_on=1, pixel_idx=0.
  - Deactivate slot0 and refetch → pixel_idx=2.
- Boundaries: line_y=99 or 116 for a sprite at y=100, and a slot with type=3.
  - Expected: rows cleared, pixel_on=0 across the span, no ROM address issued.
- Abort: second line_start 2 cycles into a fetch.
  - Expected: no line_ready until NUM_SPR+1 cycles after the second pulse; old display contents still drawn meanwhile.
- Reset_n=0 mid-FETCH.
  - Expected: next cycle busy=0, pixel_on=0 and line_ready never pulses.
